// File: rtl/bram0_loader_pkg.sv
// Shared definitions for the BRAM0 loader and the accumulate reader status FSM.
package bram0_loader_pkg;

    // Status encodings shared with the accumulate reader.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Default widths.
    localparam int unsigned DEF_DWIDTH        = 32;
    localparam int unsigned DEF_IN_DATA_WIDTH = 8;
    localparam int unsigned DEF_AWIDTH        = 8;
    localparam int unsigned DEF_MEM_SIZE      = 256;
    localparam int unsigned DEF_CNT_BIT       = DEF_AWIDTH + 1;

    // Byte lanes per BRAM0 row.
    localparam int unsigned LANES = DEF_DWIDTH / DEF_IN_DATA_WIDTH;

    // Lane counter width; at least one bit so a single-lane build still elaborates.
    function automatic int unsigned lane_bits(input int unsigned lanes);
        return (lanes > 1) ? $clog2(lanes) : 1;
    endfunction

endpackage

// File: rtl/bram0_loader_if.sv
// Host-side valid/ready byte stream feeding the BRAM0 loader.
interface bram0_loader_if
    import bram0_loader_pkg::*;
#(
    parameter int unsigned IN_DATA_WIDTH = DEF_IN_DATA_WIDTH
);
    logic [IN_DATA_WIDTH-1:0] in_data;
    logic                     in_valid;
    logic                     in_ready;

    modport master (output in_data, output in_valid, input in_ready);
    modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/bram0_loader_byte_packer.sv
// Packs stream bytes into rows, lane 0 in the low bits. The final byte of a row
// is merged combinationally so the row is available in the same cycle it arrives.
module bram0_loader_byte_packer
    import bram0_loader_pkg::*;
#(
    parameter int unsigned DWIDTH        = DEF_DWIDTH,
    parameter int unsigned IN_DATA_WIDTH = DEF_IN_DATA_WIDTH
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     clear_i,
    input  logic                     xfer_i,
    input  logic [IN_DATA_WIDTH-1:0] data_i,
    output logic [DWIDTH-1:0]        row_data_o,
    output logic                     row_valid_o
);
    localparam int unsigned NL = DWIDTH / IN_DATA_WIDTH;
    localparam int unsigned LW = lane_bits(NL);

    logic [LW-1:0]     lane_q, lane_d;
    logic [DWIDTH-1:0] buf_q, buf_d;
    logic              last_lane;

    assign last_lane = (lane_q == LW'(NL - 1));

    // Lane counter and pack buffer update on each accepted byte.
    always_comb begin
        lane_d = lane_q;
        buf_d  = buf_q;
        if (clear_i) begin
            lane_d = '0;
        end else if (xfer_i) begin
            buf_d[lane_q * IN_DATA_WIDTH +: IN_DATA_WIDTH] = data_i;
            lane_d = last_lane ? '0 : lane_q + LW'(1);
        end
    end

    // Row output: buffered lower lanes plus the byte arriving now in the top lane.
    always_comb begin
        row_data_o = buf_q;
        row_data_o[DWIDTH-1 -: IN_DATA_WIDTH] = data_i;
        row_valid_o = xfer_i && last_lane;
    end

    // Packer state registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lane_q <= '0;
            buf_q  <= '0;
        end else begin
            lane_q <= lane_d;
            buf_q  <= buf_d;
        end
    end

endmodule

// File: rtl/bram0_loader.sv
// BRAM0 loader: accepts a byte stream, packs it into rows and writes them to
// BRAM0 at sequential addresses from 0, reporting IDLE/RUN/DONE status.
module bram0_loader
    import bram0_loader_pkg::*;
#(
    parameter int unsigned DWIDTH        = DEF_DWIDTH,
    parameter int unsigned IN_DATA_WIDTH = DEF_IN_DATA_WIDTH,
    parameter int unsigned AWIDTH        = DEF_AWIDTH,
    parameter int unsigned MEM_SIZE      = DEF_MEM_SIZE,
    parameter int unsigned CNT_BIT       = DEF_CNT_BIT
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start_load_i,
    input  logic [CNT_BIT-1:0] load_count_i,
    bram0_loader_if.slave      s_if,
    output logic               idle_o,
    output logic               load_o,
    output logic               done_o,
    output logic [AWIDTH-1:0]  addr_b0_o,
    output logic               ce_b0_o,
    output logic               we_b0_o,
    output logic [DWIDTH-1:0]  d_b0_o
);
    state_e             state_q, state_d;
    logic [CNT_BIT-1:0] rows_q, rows_d;
    logic [CNT_BIT-1:0] row_cnt_q, row_cnt_d;
    logic               ready_q, ready_d;
    logic               ce_q, ce_d;
    logic [AWIDTH-1:0]  addr_q, addr_d;
    logic [DWIDTH-1:0]  data_q, data_d;
    logic               done_q, done_d;
    logic               idle_q, idle_d;

    logic               start_acc;
    logic               xfer;
    logic [DWIDTH-1:0]  row_data;
    logic               row_valid;
    logic [CNT_BIT-1:0] rows_clamped;

    assign start_acc    = (state_q == ST_IDLE) && start_load_i;
    assign xfer         = s_if.in_valid && ready_q;
    assign rows_clamped = (load_count_i > CNT_BIT'(MEM_SIZE)) ? CNT_BIT'(MEM_SIZE) : load_count_i;

    bram0_loader_byte_packer #(
        .DWIDTH        (DWIDTH),
        .IN_DATA_WIDTH (IN_DATA_WIDTH)
    ) u_packer (
        .clk         (clk),
        .reset_n     (reset_n),
        .clear_i     (start_acc),
        .xfer_i      (xfer),
        .data_i      (s_if.in_data),
        .row_data_o  (row_data),
        .row_valid_o (row_valid)
    );

    // Next-state and registered-output logic. In RUN, ready low means either a
    // zero count or that the last row's write is going out this cycle, so both
    // cases move to DONE on the following edge.
    always_comb begin
        state_d   = state_q;
        rows_d    = rows_q;
        row_cnt_d = row_cnt_q;
        ready_d   = ready_q;
        ce_d      = 1'b0;
        addr_d    = addr_q;
        data_d    = data_q;
        done_d    = 1'b0;
        idle_d    = idle_q;
        case (state_q)
            ST_IDLE: begin
                idle_d = 1'b1;
                if (start_load_i) begin
                    state_d   = ST_RUN;
                    rows_d    = rows_clamped;
                    row_cnt_d = '0;
                    ready_d   = (load_count_i != '0);
                    idle_d    = 1'b0;
                end
            end
            ST_RUN: begin
                if (!ready_q) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end else if (row_valid) begin
                    ce_d      = 1'b1;
                    addr_d    = row_cnt_q[AWIDTH-1:0];
                    data_d    = row_data;
                    row_cnt_d = row_cnt_q + CNT_BIT'(1);
                    if (row_cnt_q == rows_q - CNT_BIT'(1)) begin
                        ready_d = 1'b0;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                idle_d  = 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
                ready_d = 1'b0;
                idle_d  = 1'b1;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            rows_q    <= '0;
            row_cnt_q <= '0;
            ready_q   <= 1'b0;
            ce_q      <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
            done_q    <= 1'b0;
            idle_q    <= 1'b1;
        end else begin
            state_q   <= state_d;
            rows_q    <= rows_d;
            row_cnt_q <= row_cnt_d;
            ready_q   <= ready_d;
            ce_q      <= ce_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            done_q    <= done_d;
            idle_q    <= idle_d;
        end
    end

    assign s_if.in_ready = ready_q;
    assign idle_o        = idle_q;
    assign done_o        = done_q;
    assign ce_b0_o       = ce_q;
    assign we_b0_o       = ce_q;
    assign load_o        = ce_q;
    assign addr_b0_o     = addr_q;
    assign d_b0_o        = data_q;

endmodule

// File: doc/bram0_loader.md
Name: bram0_loader

Overview:
- Writer-side counterpart of the BRAM0 accumulate reader. It fills BRAM0 before the reader runs.
- Accepts a valid/ready byte stream from the host side and packs 4 bytes into each 32-bit row, lane 0 in bits [7:0].
- Writes rows to BRAM0 at sequential addresses from 0, for a row count given at start.
- Exposes IDLE/RUN/DONE status, so the controller sequences: load, then run the accumulate reader.

Parameters:
- DWIDTH, 32, BRAM0 row width.
- IN_DATA_WIDTH, 8, byte/lane width; DWIDTH/IN_DATA_WIDTH = 4 lanes per row.
- AWIDTH, 8, BRAM0 address width.
- MEM_SIZE, 256, BRAM0 depth in rows.
- CNT_BIT, 9, width of the row count (AWIDTH+1, so a count of MEM_SIZE is expressible).

Ports:
- clk  in  1  clock; single clock domain.
- reset_n  in  1  asynchronous, active-low reset.
- start_load_i  in  1  start pulse; sampled only in IDLE.
- load_count_i  in  CNT_BIT  number of rows to write; latched at start.
- in_data_i  in  IN_DATA_WIDTH  stream byte.
- in_valid_i  in  1  stream byte valid.
- in_ready_o  out  1  loader can accept a byte.
- idle_o  out  1  IDLE state.
- load_o  out  1  a BRAM0 write is issued this cycle (equal to ce_b0_o).
- done_o  out  1  one-cycle DONE pulse.
- addr_b0_o  out  AWIDTH  BRAM0 address.
- ce_b0_o  out  1  BRAM0 chip enable.
- we_b0_o  out  1  BRAM0 write enable.
- d_b0_o  out  DWIDTH  BRAM0 write data.

Behaviour:
- Reset values:
  - idle_o=1.
  - in_ready_o=0, load_o=0, done_o=0.
  - ce_b0_o=0, we_b0_o=0.
  - addr_b0_o=0, d_b0_o=0.
  - All counters and the pack buffer are 0.
- All outputs are registered.
- FSM:
  - IDLE -> RUN on start_load_i.
  - RUN -> DONE one cycle after the last row's write is issued.
  - DONE -> IDLE unconditionally after one cycle.
- Start in RUN or DONE is ignored.
- Count latch: rows = min(load_count_i, MEM_SIZE), latched on the start edge. Later changes to load_count_i have no effect.
- Start timing: with start accepted at cycle T, RUN and in_ready_o=1 hold from T+1.
- Transfer rule: a byte transfers when in_valid_i && in_ready_o.
  - Byte index b (0..3) is written into bits [8b+7:8b].
  - The lane counter wraps 3 -> 0.
- Row write timing: when byte 3 of row k transfers at cycle t, then at t+1:
  - ce_b0_o=1, we_b0_o=1, load_o=1.
  - addr_b0_o=k.
  - d_b0_o = the full row (byte 3 is included directly, not via the buffer).
- Write signals last exactly one cycle.
- No stall: in_ready_o stays high across row boundaries, so back-to-back bytes reach full throughput of 1 row per 4 cycles.
- in_ready_o falls in the cycle after the last byte of row rows-1 transfers. No further bytes are accepted.
- done_o=1 in the cycle after the last write (t+2). idle_o=1 from t+3.
- Between writes, ce_b0_o=0 and we_b0_o=0. addr_b0_o and d_b0_o hold their last values.
- Zero count: load_count_i=0 gives RUN for 1 cycle with in_ready_o=0 and no writes, then DONE, then IDLE.
- Count above MEM_SIZE: clamped to MEM_SIZE, so the address never wraps.
- Reset mid-operation: asynchronous return to the reset values. Any partially packed row is discarded and no write is issued.
- in_valid_i while in_ready_o=0 is ignored and the byte is not consumed.

Decomposition:
- Shared package holds:
  - state encodings IDLE/RUN/DONE, shared with the accumulate reader's status FSM;
  - LANES = DWIDTH/IN_DATA_WIDTH;
  - default widths.
- Sub-module byte_packer holds:
  - the lane counter and shift/pack buffer;
  - output ports row_data and row_valid.
- The top level holds the FSM, the row/address counter, the count clamp and the BRAM0 output registers.

Test Plan:
- Start with count 2 and stream bytes 01..08 continuously. Expect:
  - two writes: addr 0 with d=0x04030201, and addr 1 with d=0x08070605, each 1 cycle after its 4th byte;
  - done_o 1 cycle after the second write, then idle_o.
- Count 1, with in_valid_i toggling 1/0 every cycle over bytes AA, BB, CC, DD. Expect:
  - a single write of 0xDDCCBBAA at addr 0;
  - only 4 bytes consumed;
  - in_ready_o=0 after the 4th byte.
- Count 0. Expect no ce_b0_o pulse, done_o 2 cycles after start, and idle_o restored.
- Count 300, streaming an incrementing byte pattern. Expect:
  - exactly 256 writes at addresses 0..255 with no wrap;
  - in_ready_o low after byte 1024.
- Assert reset_n low after 6 bytes of a count-4 load. Expect:
  - all outputs at reset values immediately;
  - the next load (count 1, bytes 11..14) writes 0x14131211 at addr 0.
- Pulse start_load_i during RUN with a different count. Expect it ignored, with the original row count completed.
